split_check_sequencer: RTL

- Stage directly upstream of the split constraint checkers. Loads candidate variable assignments through a valid/ready write stream and drives them, held stable, onto the flattened variable bus that the combinational split_* modules read.
- After a settle window it samples every split's x output and reports pass/fail per attempt, together with an attempt count, to the solver controller.

---
 rtl/split_check_sequencer.sv | 115 +++++++++++
 1 files changed

// File: rtl/split_check_sequencer.sv
// Split check sequencer: loads candidate assignments, holds them on the
// variable bus, samples split checker results and reports each attempt.
module split_check_sequencer #(
  parameter int NUM_VARS   = 150,
  parameter int MAX_W      = 16,
  parameter int NUM_SPLITS = 32,
  parameter int IDX_W      = 8,
  parameter int SETTLE_CYC = 1,
  parameter int CNT_W      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [IDX_W-1:0]          in_idx,
  input  logic [MAX_W-1:0]          in_data,
  input  logic                      in_last,
  output logic [NUM_VARS*MAX_W-1:0] var_flat,
  input  logic [NUM_SPLITS-1:0]     split_x,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic                      res_pass,
  output logic [NUM_SPLITS-1:0]     res_fail_mask,
  output logic [CNT_W-1:0]          res_attempts,
  output logic                      err_idx,
  input  logic                      err_clr
);

  typedef enum logic [1:0] {
    LOAD,
    SETTLE,
    EVAL,
    REPORT
  } state_t;

  localparam logic [IDX_W:0] NV_LIM = NUM_VARS[IDX_W:0];

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       settle_cnt;
  logic             settle_done;
  logic             beat;
  logic             idx_ok;
  logic [MAX_W-1:0] slots [NUM_VARS];

  assign beat        = in_valid & in_ready;
  assign idx_ok      = {1'b0, in_idx} < NV_LIM;
  assign settle_done = settle_cnt == 4'(SETTLE_CYC);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      LOAD:    if (beat && in_last) state_nxt = SETTLE;
      SETTLE:  if (settle_done)     state_nxt = EVAL;
      EVAL:                         state_nxt = REPORT;
      REPORT:  if (res_ready)       state_nxt = LOAD;
      default:                      state_nxt = LOAD;
    endcase
  end

  // Handshake outputs decoded from the state
  always_comb begin
    in_ready  = (state == LOAD) && !rst;
    res_valid = (state == REPORT);
  end

  // Settle counter runs only while the bus is being held
  always_ff @(posedge clk) begin
    if (rst || state != SETTLE) settle_cnt <= '0;
    else                        settle_cnt <= settle_cnt + 4'd1;
  end

  // Slot storage; out-of-range writes are dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_VARS; i++) slots[i] <= '0;
    end else if (beat && idx_ok) begin
      slots[in_idx] <= in_data;
    end
  end

  // Result capture and attempt counting
  always_ff @(posedge clk) begin
    if (rst) begin
      res_pass      <= 1'b0;
      res_fail_mask <= '0;
      res_attempts  <= '0;
    end else if (state == EVAL) begin
      res_pass      <= &split_x;
      res_fail_mask <= ~split_x;
      if (res_attempts != '1) res_attempts <= res_attempts + CNT_W'(1);
    end else if (state == REPORT && res_ready && res_pass) begin
      res_attempts  <= '0;
    end
  end

  // Sticky index error; a new error beats a clear in the same cycle
  always_ff @(posedge clk) begin
    if (rst)                  err_idx <= 1'b0;
    else if (beat && !idx_ok) err_idx <= 1'b1;
    else if (err_clr)         err_idx <= 1'b0;
  end

  for (genvar g = 0; g < NUM_VARS; g++) begin : g_flat
    assign var_flat[g*MAX_W +: MAX_W] = slots[g];
  end

endmodule
